// File: rtl/syst_deskew.sv
// Output-side collector for the systolic array: undoes the per-lane staircase skew
// and buffers re-aligned packed words in a FIFO drained over a valid/ready handshake.

module syst_deskew_lane #(
    parameter int W      = 8,
    parameter int STAGES = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] din,
    input  logic         vin,
    output logic [W-1:0] dout,
    output logic         vout
);
    logic [STAGES-1:0][W-1:0] dat_pipe;
    logic [STAGES-1:0]        vld_pipe;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_pipe <= '0;
            vld_pipe <= '0;
        end else begin
            dat_pipe[0] <= din;
            vld_pipe[0] <= vin;
            for (int s = 1; s < STAGES; s++) begin
                dat_pipe[s] <= dat_pipe[s-1];
                vld_pipe[s] <= vld_pipe[s-1];
            end
        end
    end

    assign dout = dat_pipe[STAGES-1];
    assign vout = vld_pipe[STAGES-1];
endmodule

module syst_deskew #(
    parameter int N_LANES = 4,
    parameter int W       = 8,
    parameter int DEPTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_LANES*W-1:0]    data_i,
    input  logic [N_LANES-1:0]      valid_i,
    output logic [N_LANES*W-1:0]    data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic                    align_err_o,
    input  logic                    clr_flags_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N_LANES-1:0][W-1:0] ad;
    logic [N_LANES-1:0]        av;

    // Lane k waits N_LANES-1-k cycles so every lane lines up with the last one.
    genvar k;
    generate
        for (k = 0; k < N_LANES - 1; k++) begin : g_lane
            syst_deskew_lane #(.W(W), .STAGES(N_LANES - 1 - k)) u_lane (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .din   (data_i[k*W +: W]),
                .vin   (valid_i[k]),
                .dout  (ad[k]),
                .vout  (av[k])
            );
        end
    endgenerate

    assign ad[N_LANES-1] = data_i[(N_LANES-1)*W +: W];
    assign av[N_LANES-1] = valid_i[N_LANES-1];

    logic [N_LANES*W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 push_req, partial, full, pop, push, ovf_set;

    assign push_req = &av;
    assign partial  = (|av) && !push_req;
    assign full     = (count == CW'(DEPTH));
    assign pop      = (count != '0) && ready_i;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= ad;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            align_err_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set)          overflow_o <= 1'b1;
            else if (clr_flags_i) overflow_o <= 1'b0;
            if (partial)          align_err_o <= 1'b1;
            else if (clr_flags_i) align_err_o <= 1'b0;
        end
    end

    assign count_o = count;
    assign valid_o = (count != '0);
    assign data_o  = valid_o ? mem[rd_ptr] : '0;
endmodule
